// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and codes for the UDB shift-datapath sequencer.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Datapath configuration addresses
    localparam logic [2:0] CS_IDLE  = 3'd0;
    localparam logic [2:0] CS_SHIFT = 3'd1;
    localparam logic [2:0] CS_LOAD  = 3'd2;

    // Shift-in source selection
    localparam logic [1:0] SI_ZERO = 2'd0;
    localparam logic [1:0] SI_ONE  = 2'd1;
    localparam logic [1:0] SI_STEP = 2'd2;
    localparam logic [1:0] SI_RSVD = 2'd3;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Datapath-side signals between the sequencer and the UDB shift datapath.
interface shift_seq_ctrl_if;

    logic [2:0] cs_addr;
    logic       route_si;
    logic       f0_load;
    logic       fifo_empty;

    modport master (
        output cs_addr,
        output route_si,
        output f0_load,
        input  fifo_empty
    );

    modport slave (
        input  cs_addr,
        input  route_si,
        input  f0_load,
        output fifo_empty
    );

endinterface

// File: rtl/shift_seq_ctrl_div.sv
// Phase timer: counts clocks within one sclk phase, tick on the last one.
module shift_seq_div #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Restart at the start of each phase, otherwise count up
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == div);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the 32-bit UDB shift datapath: frames words, drives sclk,
// cs_addr and shift-in, and reports busy/done/underflow.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned DIV_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] word_len,
    input  logic [7:0]       word_cnt,
    input  logic [1:0]       si_mode,
    shift_seq_ctrl_if.master dp,
    output logic             sclk,
    output logic             busy,
    output logic             done,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WORD_BITS);

    state_t           state, state_nxt;
    logic             stop_pend;
    logic [CNT_W-1:0] bit_cnt, bit_inc, eff_len;
    logic [7:0]       word_ctr, word_inc;
    logic [3:0]       step_cnt, step_cnt_inc, step;
    logic             step_hit, si_bit;
    logic             tick, phase_load;
    logic             go, load_ok, underrun, shift, word_end;

    assign bit_inc      = bit_cnt + 1'b1;
    assign word_inc     = word_ctr + 1'b1;
    assign step_cnt_inc = step_cnt + 1'b1;
    assign step_hit     = (step_cnt_inc == step);

    // Effective word length: 0 or oversize selects the full datapath width
    always_comb begin
        eff_len = word_len;
        if (word_len == '0 || word_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    // Shift-in bit for the current SHIFT clock
    always_comb begin
        si_bit = 1'b0;
        case (si_mode)
            SI_ONE:           si_bit = 1'b1;
            SI_STEP:          si_bit = step_hit;
            SI_ZERO, SI_RSVD: si_bit = 1'b0;
            default:          si_bit = 1'b0;
        endcase
    end

    // Timer restarts outside the sclk phases and at each phase boundary
    assign phase_load = tick || !(state == ST_LOW || state == ST_HIGH);

    shift_seq_div #(.DIV_W(DIV_W)) u_div (
        .clock (clock),
        .reset (reset),
        .load  (phase_load),
        .div   (div),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-clock strobes; enable low aborts with no strobe
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        load_ok   = 1'b0;
        underrun  = 1'b0;
        shift     = 1'b0;
        word_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && enable) begin
                    go        = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (dp.fifo_empty) begin
                    underrun  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    load_ok   = 1'b1;
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    shift = 1'b1;
                    if (bit_inc == eff_len) begin
                        word_end = 1'b1;
                        if (stop_pend || stop ||
                            (word_cnt != '0 && word_inc == word_cnt)) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_LOAD;
                        end
                    end else begin
                        state_nxt = ST_LOW;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Transfer counters, sticky flags and the step-pattern generator
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stop_pend <= 1'b0;
            underflow <= 1'b0;
            bit_cnt   <= '0;
            word_ctr  <= '0;
            step_cnt  <= '0;
            step      <= 4'd1;
        end else begin
            // A stop arriving with start is kept because state_nxt leaves IDLE
            if (state_nxt == ST_IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop) begin
                stop_pend <= 1'b1;
            end
            if (go) begin
                underflow <= 1'b0;
                bit_cnt   <= '0;
                word_ctr  <= '0;
            end
            if (underrun) begin
                underflow <= 1'b1;
            end
            if (shift) begin
                bit_cnt <= word_end ? '0 : bit_inc;
                if (word_end) begin
                    word_ctr <= word_inc;
                end
                if (si_mode == SI_STEP) begin
                    if (step_hit) begin
                        step_cnt <= '0;
                        step     <= step + 1'b1;
                    end else begin
                        step_cnt <= step_cnt_inc;
                    end
                end
            end
        end
    end

    assign dp.cs_addr  = shift ? CS_SHIFT : (load_ok ? CS_LOAD : CS_IDLE);
    assign dp.route_si = shift & si_bit;
    assign dp.f0_load  = 1'b0;
    assign sclk        = (state == ST_HIGH);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

endmodule
